ahb_burst_master_ctrl: RTL and testbench

AHB_BURST_MASTER_CTRL -- requirements
Module: ahb_burst_master_ctrl

---
 rtl/ahb_pkg.sv | 63 ++++++
 rtl/ahb_burst_master_ctrl_if.sv | 45 ++++
 rtl/ahb_addr_gen.sv | 23 ++
 rtl/ahb_burst_master_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_ahb_burst_master_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB constants, command payload, FSM state and burst helpers
// for the burst master controller.
package ahb_pkg;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned LEN_W   = 5;
   localparam int unsigned BURST_W = 3;
   localparam int unsigned SIZE_W  = 3;
   localparam int unsigned TRANS_W = 2;
   localparam int unsigned RESP_W  = 2;

   localparam logic [TRANS_W-1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [TRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [TRANS_W-1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [BURST_W-1:0] HBURST_SINGLE = 3'b000;
   localparam logic [BURST_W-1:0] HBURST_INCR   = 3'b001;
   localparam logic [BURST_W-1:0] HBURST_WRAP4  = 3'b010;
   localparam logic [BURST_W-1:0] HBURST_INCR4  = 3'b011;
   localparam logic [BURST_W-1:0] HBURST_WRAP8  = 3'b100;
   localparam logic [BURST_W-1:0] HBURST_INCR8  = 3'b101;
   localparam logic [BURST_W-1:0] HBURST_WRAP16 = 3'b110;
   localparam logic [BURST_W-1:0] HBURST_INCR16 = 3'b111;

   localparam logic [RESP_W-1:0] HRESP_OKAY  = 2'b00;
   localparam logic [RESP_W-1:0] HRESP_ERROR = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_ADDR  = 3'd2,
      ST_LAST  = 3'd3,
      ST_ABORT = 3'd4
   } state_e;

   // Command attributes that stay constant for the whole transfer
   typedef struct packed {
      logic               write;
      logic [BURST_W-1:0] burst;
      logic [SIZE_W-1:0]  size;
   } cmd_t;

   function automatic logic [LEN_W-1:0] burst_beats(input logic [BURST_W-1:0] burst,
                                                    input logic [LEN_W-1:0]   len);
      case (burst)
         HBURST_SINGLE:               return LEN_W'(1);
         HBURST_INCR:                 return (len == '0) ? LEN_W'(1) : len;
         HBURST_WRAP4, HBURST_INCR4:  return LEN_W'(4);
         HBURST_WRAP8, HBURST_INCR8:  return LEN_W'(8);
         default:                     return LEN_W'(16);
      endcase
   endfunction

   function automatic logic is_wrap(input logic [BURST_W-1:0] burst);
      return (burst == HBURST_WRAP4) || (burst == HBURST_WRAP8) || (burst == HBURST_WRAP16);
   endfunction

   function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] size);
      return (size > SIZE_W'(2)) ? SIZE_W'(2) : size;
   endfunction

endpackage

// File: rtl/ahb_burst_master_ctrl_if.sv
// Command, write/read stream and AHB master signals of the burst controller.
interface ahb_burst_master_ctrl_if;
   import ahb_pkg::*;

   logic                cmd_valid;
   logic                cmd_ready;
   logic [ADDR_W-1:0]   cmd_addr;
   logic                cmd_write;
   logic [BURST_W-1:0]  cmd_burst;
   logic [LEN_W-1:0]    cmd_len;
   logic [SIZE_W-1:0]   cmd_size;
   logic [DATA_W-1:0]   wr_data;
   logic                wr_pop;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_valid;
   logic                done;
   logic                err;

   logic                Hreq;
   logic                Hgrant;
   logic                Hready;
   logic [RESP_W-1:0]   Hresp;
   logic [DATA_W-1:0]   Hrdata;
   logic [ADDR_W-1:0]   Haddr;
   logic [TRANS_W-1:0]  Htrans;
   logic                Hwrite;
   logic [SIZE_W-1:0]   Hsize;
   logic [BURST_W-1:0]  Hburst;
   logic [DATA_W-1:0]   Hwdata;

   modport master (
      input  cmd_valid, cmd_addr, cmd_write, cmd_burst, cmd_len, cmd_size, wr_data,
      input  Hgrant, Hready, Hresp, Hrdata,
      output cmd_ready, wr_pop, rd_data, rd_valid, done, err,
      output Hreq, Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_write, cmd_burst, cmd_len, cmd_size, wr_data,
      output Hgrant, Hready, Hresp, Hrdata,
      input  cmd_ready, wr_pop, rd_data, rd_valid, done, err,
      input  Hreq, Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata
   );

endinterface

// File: rtl/ahb_addr_gen.sv
// Next beat address: increments by the transfer size, wrapping at the
// burst-size-aligned boundary for WRAP bursts.
module ahb_addr_gen
   import ahb_pkg::*;
(
   input  logic [ADDR_W-1:0]  addr,
   input  logic [SIZE_W-1:0]  size,
   input  logic [BURST_W-1:0] burst,
   output logic [ADDR_W-1:0]  next_addr_c
);

   logic [ADDR_W-1:0] step;
   logic [ADDR_W-1:0] incr;
   logic [ADDR_W-1:0] wrap_mask;

   always_comb begin
      step        = ADDR_W'(1) << size;
      incr        = addr + step;
      wrap_mask   = (ADDR_W'(burst_beats(burst, LEN_W'(0))) << size) - ADDR_W'(1);
      next_addr_c = is_wrap(burst) ? ((addr & ~wrap_mask) | (incr & wrap_mask)) : incr;
   end

endmodule

// File: rtl/ahb_burst_master_ctrl.sv
// AHB burst master: takes one command at a time, arbitrates for the bus and
// issues the burst, handling wait states, grant loss and ERROR responses.
module ahb_burst_master_ctrl
   import ahb_pkg::*;
(
   input  logic                    Hclk,
   input  logic                    Hresetn,
   ahb_burst_master_ctrl_if.master bus
);

   state_e              state_q, state_d;
   cmd_t                cmd_q, cmd_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                restart_q, restart_d;
   logic                dp_v_q, dp_v_d;
   logic                dp_wr_q, dp_wr_d;

   logic                cmd_ready_q, cmd_ready_d;
   logic                wr_pop_q, wr_pop_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                hreq_q, hreq_d;
   logic [ADDR_W-1:0]   haddr_q, haddr_d;
   logic [TRANS_W-1:0]  htrans_q, htrans_d;
   logic                hwrite_q, hwrite_d;
   logic [SIZE_W-1:0]   hsize_q, hsize_d;
   logic [BURST_W-1:0]  hburst_q, hburst_d;
   logic [DATA_W-1:0]   hwdata_q, hwdata_d;

   logic [ADDR_W-1:0]   next_addr_c;
   logic                dp_err_c;
   logic                accept_c;

   ahb_addr_gen u_addr_gen (
      .addr        (addr_q),
      .size        (cmd_q.size),
      .burst       (cmd_q.burst),
      .next_addr_c (next_addr_c)
   );

   // An address phase is taken only when no ERROR is pending on the data phase
   assign dp_err_c = dp_v_q && (bus.Hresp == HRESP_ERROR);
   assign accept_c = (state_q == ST_ADDR) && bus.Hready && !dp_err_c;

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      rem_d       = rem_q;
      addr_d      = addr_q;
      restart_d   = restart_q;
      dp_v_d      = dp_v_q;
      dp_wr_d     = dp_wr_q;
      cmd_ready_d = cmd_ready_q;
      rd_data_d   = rd_data_q;
      hreq_d      = hreq_q;
      haddr_d     = haddr_q;
      htrans_d    = htrans_q;
      hwrite_d    = hwrite_q;
      hsize_d     = hsize_q;
      hburst_d    = hburst_q;
      hwdata_d    = hwdata_q;
      wr_pop_d    = 1'b0;
      rd_valid_d  = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;

      // Data-phase pipeline, independent of which state issued the address
      if (bus.Hready) begin
         dp_v_d  = accept_c;
         dp_wr_d = cmd_q.write;
      end
      if (dp_v_q && bus.Hready && !dp_wr_q && (bus.Hresp == HRESP_OKAY)) begin
         rd_valid_d = 1'b1;
         rd_data_d  = bus.Hrdata;
      end
      if (accept_c && cmd_q.write) begin
         wr_pop_d = 1'b1;
         hwdata_d = bus.wr_data;
      end else if (dp_v_q && bus.Hready) begin
         hwdata_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               cmd_d.write = bus.cmd_write;
               cmd_d.burst = bus.cmd_burst;
               cmd_d.size  = clamp_size(bus.cmd_size);
               rem_d       = burst_beats(bus.cmd_burst, bus.cmd_len);
               addr_d      = bus.cmd_addr;
               restart_d   = 1'b0;
               cmd_ready_d = 1'b0;
               hreq_d      = 1'b1;
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.Hgrant && bus.Hready) begin
               state_d  = ST_ADDR;
               htrans_d = HTRANS_NONSEQ;
               haddr_d  = addr_q;
               hwrite_d = cmd_q.write;
               hsize_d  = cmd_q.size;
               hburst_d = restart_q ? HBURST_INCR : cmd_q.burst;
            end
         end
         ST_ADDR: begin
            if (accept_c) begin
               rem_d  = rem_q - LEN_W'(1);
               addr_d = next_addr_c;
               if (rem_q == LEN_W'(1)) begin
                  state_d  = ST_LAST;
                  htrans_d = HTRANS_IDLE;
                  haddr_d  = '0;
                  hreq_d   = 1'b0;
               end else if (bus.Hgrant) begin
                  htrans_d = HTRANS_SEQ;
                  haddr_d  = next_addr_c;
               end else begin
                  // Grant lost: park, keep position, resume later as an INCR burst
                  state_d   = ST_REQ;
                  htrans_d  = HTRANS_IDLE;
                  haddr_d   = '0;
                  restart_d = 1'b1;
               end
            end
         end
         ST_LAST: begin
            if (bus.Hready && (bus.Hresp == HRESP_OKAY)) begin
               done_d      = 1'b1;
               cmd_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_ABORT: begin
            if (bus.Hready) begin
               done_d      = 1'b1;
               err_d       = 1'b1;
               cmd_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // ERROR on an outstanding data phase cancels the rest of the command
      if (dp_err_c && (state_q != ST_IDLE) && (state_q != ST_ABORT)) begin
         htrans_d = HTRANS_IDLE;
         haddr_d  = '0;
         hreq_d   = 1'b0;
         if (bus.Hready) begin
            done_d      = 1'b1;
            err_d       = 1'b1;
            cmd_ready_d = 1'b1;
            hwdata_d    = '0;
            state_d     = ST_IDLE;
         end else begin
            state_d = ST_ABORT;
         end
      end
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         rem_q       <= '0;
         addr_q      <= '0;
         restart_q   <= 1'b0;
         dp_v_q      <= 1'b0;
         dp_wr_q     <= 1'b0;
         cmd_ready_q <= 1'b1;
         wr_pop_q    <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         hreq_q      <= 1'b0;
         haddr_q     <= '0;
         htrans_q    <= HTRANS_IDLE;
         hwrite_q    <= 1'b0;
         hsize_q     <= '0;
         hburst_q    <= '0;
         hwdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         rem_q       <= rem_d;
         addr_q      <= addr_d;
         restart_q   <= restart_d;
         dp_v_q      <= dp_v_d;
         dp_wr_q     <= dp_wr_d;
         cmd_ready_q <= cmd_ready_d;
         wr_pop_q    <= wr_pop_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
         hreq_q      <= hreq_d;
         haddr_q     <= haddr_d;
         htrans_q    <= htrans_d;
         hwrite_q    <= hwrite_d;
         hsize_q     <= hsize_d;
         hburst_q    <= hburst_d;
         hwdata_q    <= hwdata_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.wr_pop    = wr_pop_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.Hreq      = hreq_q;
   assign bus.Haddr     = haddr_q;
   assign bus.Htrans    = htrans_q;
   assign bus.Hwrite    = hwrite_q;
   assign bus.Hsize     = hsize_q;
   assign bus.Hburst    = hburst_q;
   assign bus.Hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_burst_master_ctrl.sv
// Directed bench for ahb_burst_master_ctrl with a tiny AHB slave/arbiter model.
module tb_ahb_burst_master_ctrl;
   import ahb_pkg::*;

   logic Hclk;
   logic Hresetn;

   ahb_burst_master_ctrl_if bus();

   ahb_burst_master_ctrl dut (
      .Hclk    (Hclk),
      .Hresetn (Hresetn),
      .bus     (bus)
   );

   initial begin
      Hclk = 1'b0;
      forever #5 Hclk = ~Hclk;
   end

   localparam logic [110:0] RST_OUTS = {1'b1, 110'b0};

   int total = 0;
   int bad   = 0;

   logic [31:0] acc_addr[$];
   logic [31:0] acc_trans[$];
   logic [31:0] acc_burst[$];
   logic [31:0] rd_log[$];
   logic [31:0] wd_log[$];
   int          pops, dones, errs, wr_idx;
   logic        dp_v;
   logic [31:0] dp_addr;

   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] wdata_of(input int i);
      return 32'hD000_0000 + 32'(i) * 32'h11;
   endfunction

   function automatic logic [511:0] pk(input logic [31:0] q[$]);
      logic [511:0] r;
      r = '0;
      foreach (q[i]) r = {r[479:0], q[i]};
      return r;
   endfunction

   function automatic logic [110:0] outs();
      return {bus.cmd_ready, bus.wr_pop, bus.rd_data, bus.rd_valid, bus.done, bus.err,
              bus.Hreq, bus.Haddr, bus.Htrans, bus.Hwrite, bus.Hsize, bus.Hburst, bus.Hwdata};
   endfunction

   task automatic clear_logs();
      acc_addr.delete(); acc_trans.delete(); acc_burst.delete();
      rd_log.delete(); wd_log.delete();
      pops = 0; dones = 0; errs = 0; wr_idx = 0;
      dp_v = 1'b0; dp_addr = '0;
   endtask

   // One bus clock: drive slave/arbiter inputs, log accepted phases, sample pulses at +1
   task automatic bus_cycle(input logic hrdy, input logic hgnt, input logic [1:0] hresp);
      logic        nv;
      logic [31:0] na;
      bus.Hready  = hrdy;
      bus.Hgrant  = hgnt;
      bus.Hresp   = hresp;
      bus.Hrdata  = dp_v ? rdata_of(dp_addr) : 32'h0;
      bus.wr_data = wdata_of(wr_idx);
      nv = dp_v;
      na = dp_addr;
      if (hrdy) begin
         nv = bus.Htrans[1];
         na = bus.Haddr;
         if (bus.Htrans[1]) begin
            acc_addr.push_back(bus.Haddr);
            acc_trans.push_back(32'(bus.Htrans));
            acc_burst.push_back(32'(bus.Hburst));
         end
         if (dp_v && bus.Hwrite) wd_log.push_back(bus.Hwdata);
      end
      @(posedge Hclk);
      #1;
      dp_v    = nv;
      dp_addr = na;
      if (bus.wr_pop)   begin pops++; wr_idx++; end
      if (bus.rd_valid) rd_log.push_back(bus.rd_data);
      if (bus.done)     dones++;
      if (bus.err)      errs++;
   endtask

   task automatic start_cmd(input logic [31:0] addr, input logic wr, input logic [2:0] burst,
                            input logic [4:0] len, input logic [2:0] size);
      clear_logs();
      bus.cmd_addr  = addr;
      bus.cmd_write = wr;
      bus.cmd_burst = burst;
      bus.cmd_len   = len;
      bus.cmd_size  = size;
      bus.cmd_valid = 1'b1;
      bus_cycle(1'b1, 1'b1, HRESP_OKAY);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic run_to_done(input string tag, output int n);
      n = 0;
      while (dones == 0 && n < 40) begin
         bus_cycle(1'b1, 1'b1, HRESP_OKAY);
         n++;
      end
      total++;
      if (dones == 0) begin
         bad++;
         $display("FAIL %s_timeout got done=0 after %0d cycles exp done=1", tag, n);
      end
   endtask

   task automatic test_reset();
      Hresetn = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_write = 1'b0; bus.cmd_burst = '0;
      bus.cmd_len = '0; bus.cmd_size = '0; bus.wr_data = '0;
      bus.Hgrant = 1'b0; bus.Hready = 1'b1; bus.Hresp = HRESP_OKAY; bus.Hrdata = '0;
      clear_logs();
      repeat (2) @(posedge Hclk);
      #1;
      total++;
      if (outs() !== RST_OUTS) begin
         bad++; $display("FAIL reset_outs got=%h exp=%h", outs(), RST_OUTS);
      end
      Hresetn = 1'b1;
      bus_cycle(1'b1, 1'b0, HRESP_OKAY);
      total++;
      if (outs() !== RST_OUTS) begin
         bad++; $display("FAIL idle_outs got=%h exp=%h", outs(), RST_OUTS);
      end
   endtask

   task automatic test_incr4_write();
      int n;
      start_cmd(32'h100, 1'b1, HBURST_INCR4, 5'd0, 3'd2);
      run_to_done("incr4", n);
      total++;
      if (n != 6) begin bad++; $display("FAIL incr4_latency got=%0d exp=6", n); end
      total++;
      if (acc_addr.size() != 4 || pk(acc_addr) !== 512'({32'h100, 32'h104, 32'h108, 32'h10C})) begin
         bad++; $display("FAIL incr4_addr got=%h exp=100,104,108,10C", pk(acc_addr));
      end
      total++;
      if (acc_trans.size() != 4 || pk(acc_trans) !== 512'({32'h2, 32'h3, 32'h3, 32'h3})) begin
         bad++; $display("FAIL incr4_trans got=%h exp=2,3,3,3", pk(acc_trans));
      end
      total++;
      if (pk(acc_burst) !== 512'({32'h3, 32'h3, 32'h3, 32'h3})) begin
         bad++; $display("FAIL incr4_burst got=%h exp=3,3,3,3", pk(acc_burst));
      end
      total++;
      if (pops != 4 || wd_log.size() != 4 ||
          pk(wd_log) !== 512'({32'hD000_0000, 32'hD000_0011, 32'hD000_0022, 32'hD000_0033})) begin
         bad++; $display("FAIL incr4_wdata got pops=%0d data=%h exp pops=4", pops, pk(wd_log));
      end
      total++;
      if ({bus.cmd_ready, bus.Hreq, bus.Htrans, bus.err} !== 5'b10000 || errs != 0) begin
         bad++; $display("FAIL incr4_end got=%b errs=%0d exp=10000 errs=0",
                         {bus.cmd_ready, bus.Hreq, bus.Htrans, bus.err}, errs);
      end
   endtask

   task automatic test_wrap4_read();
      int n;
      start_cmd(32'h38, 1'b0, HBURST_WRAP4, 5'd0, 3'd2);
      run_to_done("wrap4", n);
      total++;
      if (acc_addr.size() != 4 || pk(acc_addr) !== 512'({32'h38, 32'h3C, 32'h30, 32'h34})) begin
         bad++; $display("FAIL wrap4_addr got=%h exp=38,3C,30,34", pk(acc_addr));
      end
      total++;
      if (rd_log.size() != 4 ||
          pk(rd_log) !== 512'({32'hA5A5_0038, 32'hA5A5_003C, 32'hA5A5_0030, 32'hA5A5_0034})) begin
         bad++; $display("FAIL wrap4_rdata got=%h exp=A5A50038,3C,30,34", pk(rd_log));
      end
      total++;
      if (pops != 0 || dones != 1) begin
         bad++; $display("FAIL wrap4_counts got pops=%0d dones=%0d exp 0 1", pops, dones);
      end
   endtask

   task automatic test_incr_len();
      int n;
      start_cmd(32'h7, 1'b0, HBURST_INCR, 5'd3, 3'd0);
      run_to_done("incr3", n);
      total++;
      if (pk(acc_addr) !== 512'({32'h7, 32'h8, 32'h9}) || pk(acc_burst) !== 512'({32'h1, 32'h1, 32'h1})
          || bus.Hsize !== 3'd0) begin
         bad++; $display("FAIL incr3_beats got addr=%h burst=%h size=%0d exp 7,8,9 INCR size0",
                         pk(acc_addr), pk(acc_burst), bus.Hsize);
      end
      start_cmd(32'h20, 1'b1, HBURST_INCR, 5'd0, 3'd5);
      run_to_done("incr0", n);
      total++;
      if (acc_addr.size() != 1 || acc_addr[0] !== 32'h20 || pops != 1 || bus.Hsize !== 3'd2) begin
         bad++; $display("FAIL incr0_single got beats=%0d pops=%0d size=%0d exp 1 1 2",
                         acc_addr.size(), pops, bus.Hsize);
      end
   endtask

   task automatic test_grant_loss();
      int n;
      start_cmd(32'h0, 1'b0, HBURST_INCR8, 5'd0, 3'd2);
      repeat (3) bus_cycle(1'b1, 1'b1, HRESP_OKAY);
      bus_cycle(1'b1, 1'b0, HRESP_OKAY);
      total++;
      if ({bus.Htrans, bus.Hreq, bus.Haddr} !== {2'b00, 1'b1, 32'h0}) begin
         bad++; $display("FAIL gloss_park got trans=%0d hreq=%0d exp trans=0 hreq=1", bus.Htrans, bus.Hreq);
      end
      bus_cycle(1'b1, 1'b0, HRESP_OKAY);
      total++;
      if ({bus.Htrans, bus.Hreq} !== 3'b001 || dones != 0) begin
         bad++; $display("FAIL gloss_wait got trans=%0d hreq=%0d dones=%0d exp 0 1 0", bus.Htrans, bus.Hreq, dones);
      end
      run_to_done("gloss", n);
      total++;
      if (pk(acc_addr) !== 512'({32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C})) begin
         bad++; $display("FAIL gloss_addr got=%h exp=0..1C step 4", pk(acc_addr));
      end
      total++;
      if (pk(acc_trans) !== 512'({32'h2, 32'h3, 32'h3, 32'h2, 32'h3, 32'h3, 32'h3, 32'h3}) ||
          pk(acc_burst) !== 512'({32'h5, 32'h5, 32'h5, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1})) begin
         bad++; $display("FAIL gloss_trans got trans=%h burst=%h exp N,S,S,N,S.. 5,5,5,1..",
                         pk(acc_trans), pk(acc_burst));
      end
      bus_cycle(1'b1, 1'b1, HRESP_OKAY);
      total++;
      if (rd_log.size() != 8 || rd_log[3] !== 32'hA5A5_000C || rd_log[7] !== 32'hA5A5_001C || dones != 1) begin
         bad++; $display("FAIL gloss_reads got n=%0d dones=%0d exp 8 reads 1 done", rd_log.size(), dones);
      end
   endtask

   task automatic test_single_wait();
      start_cmd(32'h40, 1'b1, HBURST_SINGLE, 5'd0, 3'd2);
      repeat (2) bus_cycle(1'b1, 1'b1, HRESP_OKAY);
      total++;
      if (pops != 1 || bus.Hwdata !== 32'hD000_0000 || bus.Htrans !== HTRANS_IDLE) begin
         bad++; $display("FAIL single_issue got pops=%0d hwdata=%h trans=%0d exp 1 D0000000 0",
                         pops, bus.Hwdata, bus.Htrans);
      end
      for (int i = 0; i < 3; i++) begin
         bus_cycle(1'b0, 1'b1, HRESP_OKAY);
         total++;
         if (bus.Hwdata !== 32'hD000_0000 || bus.done !== 1'b0) begin
            bad++; $display("FAIL single_wait%0d got hwdata=%h done=%0d exp D0000000 0", i, bus.Hwdata, bus.done);
         end
      end
      bus_cycle(1'b1, 1'b1, HRESP_OKAY);
      total++;
      if (bus.done !== 1'b1 || pops != 1 || bus.Hwdata !== 32'h0 || wd_log.size() != 1) begin
         bad++; $display("FAIL single_done got done=%0d pops=%0d hwdata=%h exp 1 1 0", bus.done, pops, bus.Hwdata);
      end
   endtask

   task automatic test_error();
      start_cmd(32'h200, 1'b0, HBURST_INCR4, 5'd0, 3'd2);
      repeat (3) bus_cycle(1'b1, 1'b1, HRESP_OKAY);
      bus_cycle(1'b0, 1'b1, HRESP_ERROR);
      total++;
      if ({bus.Htrans, bus.done, bus.err} !== 4'b0000) begin
         bad++; $display("FAIL err_first got trans=%0d done=%0d err=%0d exp 0 0 0", bus.Htrans, bus.done, bus.err);
      end
      bus_cycle(1'b1, 1'b1, HRESP_ERROR);
      total++;
      if ({bus.done, bus.err, bus.cmd_ready, bus.Hreq} !== 4'b1110) begin
         bad++; $display("FAIL err_done got=%b exp=1110", {bus.done, bus.err, bus.cmd_ready, bus.Hreq});
      end
      bus_cycle(1'b1, 1'b1, HRESP_OKAY);
      total++;
      if (rd_log.size() != 1 || rd_log[0] !== 32'hA5A5_0200 || dones != 1 || errs != 1 || bus.done !== 1'b0) begin
         bad++; $display("FAIL err_reads got n=%0d dones=%0d errs=%0d exp 1 1 1", rd_log.size(), dones, errs);
      end
   endtask

   task automatic test_reset_mid();
      start_cmd(32'h300, 1'b1, HBURST_INCR8, 5'd0, 3'd2);
      repeat (3) bus_cycle(1'b1, 1'b1, HRESP_OKAY);
      #2;
      Hresetn = 1'b0;
      #1;
      total++;
      if (outs() !== RST_OUTS) begin
         bad++; $display("FAIL rstmid_async got=%h exp=%h", outs(), RST_OUTS);
      end
      repeat (2) bus_cycle(1'b1, 1'b1, HRESP_OKAY);
      Hresetn = 1'b1;
      bus_cycle(1'b1, 1'b1, HRESP_OKAY);
      total++;
      if (dones != 0 || {bus.cmd_ready, bus.Hreq, bus.Htrans} !== 4'b1000) begin
         bad++; $display("FAIL rstmid_after got dones=%0d state=%b exp 0 1000",
                         dones, {bus.cmd_ready, bus.Hreq, bus.Htrans});
      end
   endtask

   initial begin
      test_reset();
      test_incr4_write();
      test_wrap4_read();
      test_incr_len();
      test_grant_loss();
      test_single_wait();
      test_error();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp test completion");
      $fatal(1, "watchdog");
   end

endmodule
